// File: rtl/inert_spi_pkg.sv
// Shared register map and frame constants for the inertial-sensor SPI responder.
package inert_spi_pkg;

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL1_XL  = 7'h10;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_CTRL3     = 7'h14;
    localparam logic [6:0] ADDR_OUTX_L_G  = 7'h22;
    localparam logic [6:0] ADDR_OUTX_H_G  = 7'h23;
    localparam logic [6:0] ADDR_OUTZ_L_XL = 7'h2C;
    localparam logic [6:0] ADDR_OUTZ_H_XL = 7'h2D;

    localparam int         RW_BIT    = 15;
    localparam int         FRAME_LEN = 16;
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_LEN);

endpackage

// File: rtl/spi_resp_phy.sv
// SPI responder physical layer: input synchronizers, edge detection,
// receive/transmit shift registers and the per-frame bit counter.
module spi_resp_phy
    import inert_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ss_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        tx_load,
    input  logic [7:0]  tx_data,
    output logic        miso,
    output logic        cmd_rdy,
    output logic        frame_done,
    output logic        ss_idle,
    output logic [4:0]  count,
    output logic [15:0] rx
);

    logic [2:0] ss_sync;
    logic [2:0] sclk_sync;
    logic [2:0] mosi_sync;
    logic       ss_fall;
    logic       ss_rise;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] tx_reg;
    logic       rd_active;
    logic       skip_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 3'b000;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[1:0], mosi};
        end
    end

    assign ss_fall    = ss_sync[2] & ~ss_sync[1];
    assign ss_rise    = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise  = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall  = sclk_sync[2] & ~sclk_sync[1];
    assign ss_idle    = ss_sync[2];
    assign frame_done = ss_rise;

    // Count saturates one past a full frame so over-clocked frames never look complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 5'd0;
            rx      <= 16'd0;
            cmd_rdy <= 1'b0;
        end else begin
            cmd_rdy <= sclk_rise && !ss_sync[2] && (count == 5'd7);
            if (ss_fall) begin
                count <= 5'd0;
                rx    <= 16'd0;
            end else if (sclk_rise && !ss_sync[2]) begin
                if (count < FRAME_CNT)
                    rx <= {rx[14:0], mosi_sync[2]};
                if (count <= FRAME_CNT)
                    count <= count + 5'd1;
            end
        end
    end

    // The master samples on SCLK rise, so bit 7 must survive the first fall after loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg    <= 8'd0;
            rd_active <= 1'b0;
            skip_fall <= 1'b0;
        end else if (ss_fall || ss_rise) begin
            tx_reg    <= 8'd0;
            rd_active <= 1'b0;
            skip_fall <= 1'b0;
        end else if (tx_load) begin
            tx_reg    <= tx_data;
            rd_active <= 1'b1;
            skip_fall <= 1'b1;
        end else if (sclk_fall && rd_active) begin
            if (skip_fall)
                skip_fall <= 1'b0;
            else
                tx_reg <= {tx_reg[6:0], 1'b0};
        end
    end

    assign miso = rd_active & tx_reg[7];

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial-sensor emulator: config register file, periodic sample snapshots
// and the INT line, served over a 16-bit SPI frame.
module inert_spi_resp
    import inert_spi_pkg::*;
#(
    parameter logic [15:0] INT_PERIOD   = 16'd4096,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] ptch_rt,
    input  logic [15:0] az,
    output logic        INT
);

    logic        cmd_rdy;
    logic        frame_done;
    logic        ss_idle;
    logic [4:0]  count;
    logic [15:0] rx;
    logic        tx_load;
    logic [7:0]  tx_data;

    logic [7:0]  int1_ctrl;
    logic [7:0]  ctrl1_xl;
    logic [7:0]  ctrl2_g;
    logic [7:0]  ctrl3;
    logic [15:0] snap_ptch;
    logic [15:0] snap_az;
    logic [15:0] timer;
    logic        pending;

    logic        enable;
    logic        wrap;
    logic        full_frame;
    logic        wr_commit;
    logic        int_clear;
    logic        capture;

    spi_resp_phy u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (SS_n),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .miso       (MISO),
        .cmd_rdy    (cmd_rdy),
        .frame_done (frame_done),
        .ss_idle    (ss_idle),
        .count      (count),
        .rx         (rx)
    );

    // At cmd_rdy the command byte still sits in rx[7:0].
    assign tx_load = cmd_rdy && rx[RW_BIT-8];

    always_comb begin
        tx_data = 8'h00;
        case (rx[6:0])
            ADDR_INT1_CTRL: tx_data = int1_ctrl;
            ADDR_CTRL1_XL:  tx_data = ctrl1_xl;
            ADDR_CTRL2_G:   tx_data = ctrl2_g;
            ADDR_CTRL3:     tx_data = ctrl3;
            ADDR_WHO_AM_I:  tx_data = WHO_AM_I_VAL;
            ADDR_OUTX_L_G:  tx_data = snap_ptch[7:0];
            ADDR_OUTX_H_G:  tx_data = snap_ptch[15:8];
            ADDR_OUTZ_L_XL: tx_data = snap_az[7:0];
            ADDR_OUTZ_H_XL: tx_data = snap_az[15:8];
            default:        tx_data = 8'h00;
        endcase
    end

    assign enable     = int1_ctrl[1] && (ctrl2_g != 8'd0);
    assign wrap       = enable && (timer == INT_PERIOD - 16'd1);
    assign full_frame = frame_done && (count == FRAME_CNT);
    assign wr_commit  = full_frame && !rx[RW_BIT];
    assign int_clear  = full_frame && rx[RW_BIT] && (rx[14:8] == ADDR_OUTX_L_G);
    // Snapshots only move while no frame is in flight; a deferred sample lands on SS_n rise.
    assign capture    = enable && (wrap || pending) && (ss_idle || frame_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl1_xl  <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl3     <= 8'h00;
        end else if (wr_commit) begin
            case (rx[14:8])
                ADDR_INT1_CTRL: int1_ctrl <= rx[7:0];
                ADDR_CTRL1_XL:  ctrl1_xl  <= rx[7:0];
                ADDR_CTRL2_G:   ctrl2_g   <= rx[7:0];
                ADDR_CTRL3:     ctrl3     <= rx[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= 16'd0;
            pending   <= 1'b0;
            INT       <= 1'b0;
            snap_ptch <= 16'd0;
            snap_az   <= 16'd0;
        end else begin
            if (!enable || wrap)
                timer <= 16'd0;
            else
                timer <= timer + 16'd1;

            pending <= enable && (wrap || pending) && !(ss_idle || frame_done);

            if (capture) begin
                snap_ptch <= ptch_rt;
                snap_az   <= az;
            end

            // Capture is checked before clear so a sample arriving with the clear keeps INT high.
            if (!enable)
                INT <= 1'b0;
            else if (capture)
                INT <= 1'b1;
            else if (int_clear)
                INT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inert_spi_resp.sv
// Randomized bench for inert_spi_resp against a transaction-level register/snapshot model.
module tb_inert_spi_resp;

    localparam int P = 2048;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic [15:0] ptch_rt = 16'd0;
    logic [15:0] az = 16'd0;
    logic        MISO;
    logic        INT;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic [7:0]  mregs [0:127];
    logic [15:0] m_snap_p = 16'd0;
    logic [15:0] m_snap_a = 16'd0;

    inert_spi_resp #(.INT_PERIOD(16'(P)), .WHO_AM_I_VAL(8'h6A)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .ptch_rt (ptch_rt),
        .az      (az),
        .INT     (INT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit writable(input logic [6:0] a);
        return (a == 7'h0D) || (a == 7'h10) || (a == 7'h11) || (a == 7'h14);
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (writable(a)) return mregs[a];
        case (a)
            7'h0F:   return 8'h6A;
            7'h22:   return m_snap_p[7:0];
            7'h23:   return m_snap_p[15:8];
            7'h2C:   return m_snap_a[7:0];
            7'h2D:   return m_snap_a[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mregs[i] = 8'h00;
        m_snap_p = 16'd0;
        m_snap_a = 16'd0;
    endtask

    task automatic spi_xfer(input logic [15:0] word, input int nbits,
                            output logic [7:0] rd, output logic miso_bad, output int unsigned t_end);
        rd = 8'h00;
        miso_bad = 1'b0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            repeat (H) @(negedge clk);
            if (word[15] && i >= 8 && i < 16) rd = {rd[6:0], MISO};
            else if (MISO !== 1'b0) miso_bad = 1'b1;
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        t_end = cyc;
        repeat (6) @(negedge clk);
        if (MISO !== 1'b0) miso_bad = 1'b1;
        $display("xfer word=%04h bits=%0d rd=%02h int=%0b", word, nbits, rd, INT);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, output int unsigned t_end);
        logic [7:0] rd;
        logic       bad;
        spi_xfer({1'b0, a, d}, 16, rd, bad, t_end);
        check("wr_miso_zero", bad, 1'b0);
        if (writable(a)) mregs[a] = d;
    endtask

    task automatic do_read(input logic [6:0] a, input string tag);
        logic [7:0]  rd;
        logic        bad;
        logic [7:0]  exp;
        int unsigned te;
        exp = model_read(a);
        spi_xfer({1'b1, a, 8'h00}, 16, rd, bad, te);
        check(tag, rd, exp);
        check("rd_cmd_miso_zero", bad, 1'b0);
    endtask

    task automatic wait_int(input int unsigned t0, input int lo, input int hi, input string tag);
        int unsigned lat;
        while (INT !== 1'b1 && (cyc - t0) <= hi) @(negedge clk);
        lat = cyc - t0;
        check(tag, (INT === 1'b1) && (lat >= lo) && (lat <= hi), 1'b1);
    endtask

    initial begin
        logic [7:0]  rd;
        logic        bad;
        logic [6:0]  a;
        logic [7:0]  d;
        int unsigned te;
        int unsigned t1;
        int unsigned t2;
        logic        int_seen;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_int", INT, 1'b0);
        check("rst_miso", MISO, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Random config traffic while disabled (INT1_CTRL bit 1 kept low).
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 5))
                0: a = 7'h0D;
                1: a = 7'h10;
                2: a = 7'h11;
                3: a = 7'h14;
                4: a = 7'h0F;
                default: begin
                    a = 7'($urandom_range(0, 127));
                    while (writable(a) || a == 7'h0F || a == 7'h22 || a == 7'h23 ||
                           a == 7'h2C || a == 7'h2D)
                        a = 7'($urandom_range(0, 127));
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                if (a == 7'h0D) d[1] = 1'b0;
                do_write(a, d, te);
            end else begin
                do_read(a, "rand_read");
            end
        end
        do_read(7'h0F, "who_am_i");
        do_read(7'h3E, "unmapped_read");
        do_write(7'h3E, 8'h55, te);
        do_read(7'h0D, "reg0d_after_bad_wr");
        do_read(7'h10, "reg10_after_bad_wr");
        do_read(7'h11, "reg11_after_bad_wr");
        do_read(7'h14, "reg14_after_bad_wr");
        do_write(7'h11, 8'h00, te);
        do_write(7'h0D, 8'h02, te);
        d = 8'($urandom);
        spi_xfer({1'b0, 7'h14, d}, 18, rd, bad, te);
        check("long_wr_miso_zero", bad, 1'b0);
        do_read(7'h14, "reg14_after_long_wr");
        check("int_while_disabled", INT, 1'b0);

        // Enable and wait for the first sample.
        ptch_rt = 16'h1234;
        az      = 16'hABCD;
        do_write(7'h11, 8'h50, te);
        wait_int(te, P + 1, P + 5, "int1_latency");
        t1 = cyc;
        m_snap_p = ptch_rt;
        m_snap_a = az;
        ptch_rt = 16'($urandom);
        az      = 16'($urandom);

        do_read(7'h22, "snap1_ptch_lo");
        check("int_cleared_by_22", INT, 1'b0);
        do_read(7'h23, "snap1_ptch_hi");
        do_read(7'h2C, "snap1_az_lo");
        do_read(7'h2D, "snap1_az_hi");

        spi_xfer({1'b0, 7'h0D, 8'h00}, 10, rd, bad, te);
        check("abort_miso_zero", bad, 1'b0);
        do_read(7'h0D, "reg0d_after_abort");

        wait_int(t1, P - 1, P + 1, "int2_period");
        t2 = cyc;
        m_snap_p = ptch_rt;
        m_snap_a = az;
        ptch_rt = 16'($urandom);
        az      = 16'($urandom);
        do_read(7'h23, "snap2_ptch_hi");
        check("int_held_by_23", INT, 1'b1);

        // Position a 0x22 read so the next wrap lands mid-frame.
        while (cyc < t2 + P - 150) @(negedge clk);
        do_read(7'h22, "midframe_snap_stable");
        m_snap_p = ptch_rt;
        m_snap_a = az;
        check("int_capture_beats_clear", INT, 1'b1);
        do_read(7'h2D, "snap3_az_hi");
        do_read(7'h22, "snap3_ptch_lo");
        check("int_cleared_again", INT, 1'b0);

        wait_int(cyc, 1, P, "int3_arrives");

        // Reset in the middle of a read frame with INT high.
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0;
            MOSI = (i == 0);
            repeat (H) @(negedge clk);
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_int", INT, 1'b0);
        check("midrst_miso", MISO, 1'b0);
        SS_n = 1'b1;
        SCLK = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        int_seen = 1'b0;
        repeat (2 * P + 100) begin
            @(negedge clk);
            if (INT === 1'b1) int_seen = 1'b1;
        end
        check("no_int_after_rst", int_seen, 1'b0);
        do_read(7'h0D, "reg0d_after_rst");
        do_read(7'h22, "snap_after_rst");

        do_write(7'h0D, 8'h02, te);
        do_write(7'h11, 8'h50, te);
        wait_int(te, P + 1, P + 5, "int_after_reenable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
